alu_wb_buffer: RTL
==================

// Module: alu_wb_buffer
// PURPOSE
//   Result buffer directly downstream of the ALU functional unit. Captures each ALU
//   result (data, branch-compare bit, trans_id) into a small in-order FIFO and
//   presents it to the scoreboard write-back port with a valid/ready handshake.
//   Decouples ALU issue from write-back arbitration stalls; flushed on mispredict/exception.
// PARAMETERS
//   XLEN           64   result width, equal to riscv::XLEN
//   TRANS_ID_BITS  3    scoreboard transaction-id width
//   DEPTH          2    FIFO entries; power of two, >= 2
// PORTS
//   clk_i            in   1                 clock
//   rst_ni           in   1                 asynchronous reset, active low
//   flush_i          in   1                 drop all buffered results
//   alu_valid_i      in   1                 ALU result valid this cycle
//   alu_ready_o      out  1                 buffer can accept (registered, = !full)
//   alu_trans_id_i   in   TRANS_ID_BITS     id of the ALU instruction
//   alu_result_i     in   XLEN              ALU result_o
//   alu_branch_res_i in   1                 ALU alu_branch_res_o
//   wb_valid_o       out  1                 head entry valid (= !empty)
//   wb_ready_i       in   1                 write-back port accepts head
//   wb_trans_id_o    out  TRANS_ID_BITS     head trans_id
//   wb_result_o      out  XLEN              head result
//   wb_branch_res_o  out  1                 head branch-compare bit
//   count_o          out  $clog2(DEPTH)+1   current occupancy
//   overflow_o       out  1                 sticky: push attempted while full
// BEHAVIOUR
//   - Reset (rst_ni=0, async): pointers/count=0, wb_valid_o=0, alu_ready_o=1,
//     overflow_o=0, wb_* data outputs=0 (storage array cleared).
//   - push = alu_valid_i & alu_ready_o; pop = wb_valid_o & wb_ready_i.
//   - Latency: entry pushed at edge N is visible on wb_* after edge N (cycle N+1);
//     no combinational path alu_* -> wb_* and none wb_ready_i -> alu_ready_o.
//   - Data outputs driven from head storage (read pointer), stable while wb_valid_o=1
//     and wb_ready_i=0; pop advances read pointer, wrapping mod DEPTH.
//   - Write pointer wraps mod DEPTH; count range 0..DEPTH; full = (count==DEPTH).
//   - Push+pop same cycle: both pointers advance, count unchanged. When full, push is
//     blocked (alu_ready_o=0) even if pop occurs; ready returns the next cycle.
//   - Push while full (alu_valid_i=1, alu_ready_o=0): input dropped, storage
//     untouched, overflow_o set and held until reset (not cleared by flush).
//   - Empty: wb_valid_o=0; wb_ready_i ignored, no pointer movement.
//   - flush_i=1: next edge count=0, pointers=0, wb_valid_o=0; any push or pop in
//     the same cycle is discarded. flush has priority over push/pop.
//   - Strict FIFO order; trans_id carried unmodified; no reordering.
//   - Reset asserted mid-transfer: all state cleared immediately, independent of clk_i.
// TESTING
//   1 Single: push id=3 result=64'hDEAD_BEEF at edge 1, wb_ready_i=1 -> wb_valid_o=1
//     cycle 2 with id=3, result=64'hDEAD_BEEF; count_o 1 then 0 after edge 2.
//   2 Backpressure: wb_ready_i=0, push ids 1,2 -> count_o=2, alu_ready_o=0; 3rd push
//     id=5 -> overflow_o=1, head stays id=1; release -> pops 1 then 2, no id 5.
//   3 Stream: count=1, wb_ready_i=1, push every cycle ids 0..7 -> count stays 1,
//     outputs ids 0..7 in order one cycle delayed, pointers wrap correctly.
//   4 Flush: count=2 with push+pop asserted and flush_i=1 -> next cycle count_o=0,
//     wb_valid_o=0, alu_ready_o=1; overflow_o unchanged.
//   5 Full with pop: count=DEPTH, wb_ready_i=1, alu_valid_i=1 -> head popped,
//     input not captured, overflow_o=1, count_o=DEPTH-1.
//   6 Async reset mid-stream: drop rst_ni between edges with count=2 -> wb_valid_o=0,
//     count_o=0, wb_result_o=0 immediately, before next clk_i edge.

Source files
------------

// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU result side, the buffer and the scoreboard
// write-back port; flush and status outputs travel with it.
interface alu_wb_buffer_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 2
);
    logic                       flush_i;
    logic                       alu_valid_i;
    logic                       alu_ready_o;
    logic [TRANS_ID_BITS-1:0]   alu_trans_id_i;
    logic [XLEN-1:0]            alu_result_i;
    logic                       alu_branch_res_i;
    logic                       wb_valid_o;
    logic                       wb_ready_i;
    logic [TRANS_ID_BITS-1:0]   wb_trans_id_o;
    logic [XLEN-1:0]            wb_result_o;
    logic                       wb_branch_res_o;
    logic [$clog2(DEPTH):0]     count_o;
    logic                       overflow_o;

    // The buffer itself
    modport slave (
        input  flush_i, alu_valid_i, alu_trans_id_i, alu_result_i, alu_branch_res_i,
               wb_ready_i,
        output alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_branch_res_o,
               count_o, overflow_o
    );

    // The surrounding pipeline driving and consuming the buffer
    modport master (
        output flush_i, alu_valid_i, alu_trans_id_i, alu_result_i, alu_branch_res_i,
               wb_ready_i,
        input  alu_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o, wb_branch_res_o,
               count_o, overflow_o
    );
endinterface

// File: rtl/alu_wb_buffer.sv
// In-order result FIFO between the ALU and the scoreboard write-back port.
// All outputs derive from registers only; no input-to-output combinational path.
module alu_wb_buffer #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned DEPTH         = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    alu_wb_buffer_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [XLEN-1:0]          result;
        logic                     branch_res;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rptr;
    logic [PW-1:0]   wptr;
    logic [CW-1:0]   count;
    logic            overflow;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    // Ready comes from the registered count, so a same-cycle pop never frees a full slot
    assign push  = bus.alu_valid_i & ~full;
    assign pop   = ~empty & bus.wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else if (bus.flush_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !bus.flush_i) begin
            mem[wptr] <= '{trans_id:   bus.alu_trans_id_i,
                           result:     bus.alu_result_i,
                           branch_res: bus.alu_branch_res_i};
        end
    end

    // Sticky until reset; a flush does not clear it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            overflow <= 1'b0;
        else if (bus.alu_valid_i && full)
            overflow <= 1'b1;
    end

    assign bus.alu_ready_o     = ~full;
    assign bus.wb_valid_o      = ~empty;
    assign bus.wb_trans_id_o   = mem[rptr].trans_id;
    assign bus.wb_result_o     = mem[rptr].result;
    assign bus.wb_branch_res_o = mem[rptr].branch_res;
    assign bus.count_o         = count;
    assign bus.overflow_o      = overflow;
endmodule
